// File: rtl/voice_pkg.sv
// Shared constants and jump-FSM state type for the PDM voice decoder.
package voice_pkg;
    localparam int CLK_DIV   = 17;
    localparam int WIN_LOG2  = 7;
    localparam int DECAY_SH  = 3;
    localparam int THRESH_HI = 32;
    localparam int THRESH_LO = 16;
    localparam int HOLD      = 4;

    typedef enum logic {IDLE, ACTIVE} jump_state_e;
endpackage

// File: rtl/pdm_clk_gen.sv
// Microphone bit-clock divider with a strobe on the cycle mic_clk falls,
// which is when the left-channel bit is valid on the data pin.
module pdm_clk_gen #(
    parameter int CLK_DIV = voice_pkg::CLK_DIV
) (
    input  logic clk_in,
    input  logic reset,
    output logic mic_clk_o,
    output logic cap_stb_o
);
    localparam int CNT_W = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mic_clk_q, mic_clk_d;
    logic             wrap;

    assign wrap = (cnt_q == CNT_W'(CLK_DIV));

    always_comb begin
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        mic_clk_d = wrap ? ~mic_clk_q : mic_clk_q;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q     <= '0;
            mic_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mic_clk_q <= mic_clk_d;
        end
    end

    assign mic_clk_o = mic_clk_q;
    assign cap_stb_o = wrap & mic_clk_q;
endmodule

// File: rtl/pdm_mic_decoder.sv
// PDM mic front end: bit capture, window decimation, peak envelope and a
// hysteretic jump detector with a minimum hold time.
module pdm_mic_decoder
    import voice_pkg::*;
#(
    parameter int CLK_DIV_P   = CLK_DIV,
    parameter int WIN_LOG2_P  = WIN_LOG2,
    parameter int DECAY_SH_P  = DECAY_SH,
    parameter int THRESH_HI_P = THRESH_HI,
    parameter int THRESH_LO_P = THRESH_LO,
    parameter int HOLD_P      = HOLD
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  micdata,
    output logic                  mic_clk,
    output logic                  mic_lr,
    output logic [WIN_LOG2_P:0]   sample,
    output logic                  sample_valid,
    output logic [WIN_LOG2_P-1:0] level,
    output logic                  jump
);
    localparam int SW = WIN_LOG2_P + 1;
    localparam int EW = WIN_LOG2_P;
    localparam int HW = (HOLD_P < 1) ? 1 : $clog2(HOLD_P + 1);
    localparam logic [SW-1:0] HALF   = SW'(2 ** (WIN_LOG2_P - 1));
    localparam logic [EW-1:0] TH_HI  = EW'(THRESH_HI_P);
    localparam logic [EW-1:0] TH_LO  = EW'(THRESH_LO_P);
    localparam logic [HW-1:0] HOLD_C = HW'(HOLD_P);

    logic cap_stb;

    pdm_clk_gen #(.CLK_DIV(CLK_DIV_P)) u_clk_gen (
        .clk_in    (clk_in),
        .reset     (reset),
        .mic_clk_o (mic_clk),
        .cap_stb_o (cap_stb)
    );

    logic          mic_q;
    logic [SW-1:0] acc_q, bit_sum;
    logic [EW-1:0] bit_cnt_q;
    logic [SW-1:0] sample_q;
    logic          sv_q;

    // The closing bit is folded into the sum so the next window starts clean.
    assign bit_sum = acc_q + {{EW{1'b0}}, mic_q};

    always_ff @(posedge clk_in) begin
        if (reset) begin
            mic_q     <= 1'b0;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            sample_q  <= '0;
            sv_q      <= 1'b0;
        end else begin
            mic_q <= micdata;
            sv_q  <= 1'b0;
            if (cap_stb) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == '1) begin
                    sample_q <= bit_sum;
                    acc_q    <= '0;
                    sv_q     <= 1'b1;
                end else begin
                    acc_q <= bit_sum;
                end
            end
        end
    end

    logic [EW-1:0] amp, env_q, env_d, dec, dec_eff;
    logic          env_upd_q;

    assign amp     = EW'((sample_q >= HALF) ? sample_q - HALF : HALF - sample_q);
    assign dec     = env_q >> DECAY_SH_P;
    assign dec_eff = (dec == '0) ? EW'(1) : dec;

    always_comb begin
        env_d = env_q;
        if (amp > env_q)     env_d = amp;
        else if (env_q != 0) env_d = env_q - dec_eff;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            env_q     <= '0;
            env_upd_q <= 1'b0;
        end else begin
            env_upd_q <= sv_q;
            if (sv_q) env_q <= env_d;
        end
    end

    jump_state_e   state_q;
    logic [HW-1:0] hold_q;
    logic          jump_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            jump_q  <= 1'b0;
        end else if (env_upd_q) begin
            case (state_q)
                IDLE: if (env_q >= TH_HI) begin
                    state_q <= ACTIVE;
                    hold_q  <= '0;
                    jump_q  <= 1'b1;
                end
                ACTIVE: begin
                    if (hold_q >= HOLD_C && env_q < TH_LO) begin
                        state_q <= IDLE;
                        jump_q  <= 1'b0;
                    end else if (hold_q < HOLD_C) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mic_lr       = 1'b0;
    assign sample       = sample_q;
    assign sample_valid = sv_q;
    assign level        = env_q;
    assign jump         = jump_q;
endmodule

// File: doc/pdm_mic_decoder.md
# pdm_mic_decoder

Hardware decoder for the on-board PDM microphone in the voice-controlled game. It drives the microphone bit clock, samples the 1-bit PDM stream, decimates it into PCM loudness samples, and turns loudness into a debounced `jump` level for the game logic. Software decoding is no longer needed for jump detection. It sits between the mic pins and the game state machine, and runs entirely in the `clk_in` domain.

## Interface
- `CLK_DIV`, 17: `mic_clk` half-period minus one, in `clk_in` cycles; period = 2*(CLK_DIV+1).
- `WIN_LOG2`, 7: decimation window of 2^WIN_LOG2 PDM bits per sample.
- `DECAY_SH`, 3: envelope decay shift.
- `THRESH_HI`, 32: envelope level that asserts `jump`.
- `THRESH_LO`, 16: envelope level below which `jump` may release.
- `HOLD`, 4: minimum samples `jump` stays asserted.

Ports:
- `clk_in`  in  1: system clock. Reset is synchronous, active-high, on `clk_in`.
- `reset`  in  1: synchronous, active-high.
- `micdata`  in  1: PDM data from the microphone.
- `mic_clk`  out  1: microphone bit clock, reset 0.
- `mic_lr`  out  1: channel select, constant 0.
- `sample`  out  WIN_LOG2+1: ones-count of the last window, reset 0.
- `sample_valid`  out  1: one-cycle strobe when `sample` updates, reset 0.
- `level`  out  WIN_LOG2: envelope value, reset 0.
- `jump`  out  1: voice-active level, reset 0.

## Operation
- **Divider.** The counter runs 0..CLK_DIV. At CLK_DIV it wraps to 0 and `mic_clk` toggles.
- **Bit capture.** `micdata` is registered every cycle. A bit is captured on the cycle the divider toggles `mic_clk` from 1 to 0, i.e. at the end of the high phase. The L channel is valid then.
- **Accumulator.** It is WIN_LOG2+1 bits wide and adds each captured bit. A bit counter of WIN_LOG2 bits counts captured bits.
- **Window end.** When the bit counter wraps after 2^WIN_LOG2 bits:
  - the final sum (including the last bit) is loaded into `sample`;
  - the accumulator restarts at 0, with no bit lost;
  - `sample_valid` pulses.
- **Amplitude.** amp = |sample − 2^(WIN_LOG2−1)|. It is WIN_LOG2 bits wide; the maximum of 2^(WIN_LOG2−1) fits.
- **Envelope.** Updated on the cycle after `sample_valid`:
  - if amp > env, env = amp;
  - else if env > 0, env = env − max(1, env>>DECAY_SH);
  - else env stays 0.
  - `level` = env.
- **FSM.** States are IDLE and ACTIVE; it evaluates on the cycle after each envelope update.
  - IDLE → ACTIVE when env ≥ THRESH_HI. hold_cnt clears to 0.
  - In ACTIVE, hold_cnt increments per sample and saturates at HOLD.
  - ACTIVE → IDLE when hold_cnt ≥ HOLD and env < THRESH_LO.
  - `jump` = (state == ACTIVE).
- **Reset mid-operation.** All registers return to reset values on the next edge and the partial window is discarded. The first post-reset window starts at the first capture after reset.

## Timing
- The `mic_clk` first rising edge occurs CLK_DIV+1 cycles after reset deasserts. With defaults the period is 36 cycles, giving about 2.78 MHz at 100 MHz.
- Window length is 2^WIN_LOG2 × 2(CLK_DIV+1) cycles; 4608 with defaults.
- Let the last-bit capture be cycle N:
  - `sample` and `sample_valid` are valid at N+1;
  - `level` updates at N+2;
  - `jump` updates at N+3.
- `sample_valid` is exactly one cycle wide and is never back-to-back.
- Sample and envelope updates occur only on window ends; the FSM only on envelope updates.
- THRESH_LO < THRESH_HI is required; behaviour is undefined otherwise.

## Structure
- Shared package `voice_pkg`:
  - default constants (CLK_DIV, WIN_LOG2, thresholds, HOLD, DECAY_SH);
  - jump FSM state typedef {IDLE, ACTIVE}.
- Sub-module `pdm_clk_gen` contains the divider, `mic_clk`, and a one-cycle capture strobe. Accumulation, envelope and FSM stay in `pdm_mic_decoder`.

## Test plan
All scenarios use default parameters.
- **Clock generation.** Reset for 3 cycles, then run → `mic_clk` first rises 18 cycles after reset release; period 36, duty 50%; `mic_lr` = 0.
- **Full-scale ones.** `micdata` held at 1 → first `sample_valid` 4608 cycles after capture start, with `sample` = 128; `level` = 64 one cycle later; `jump` = 1 one cycle after that.
- **Full-scale zeros.** `micdata` held at 0 → `sample` = 0, amp 64, `jump` asserts with the same latency as the ones case.
- **Silence.** Alternating 1/0 per `mic_clk` → `sample` = 64 every window; `level` stays 0; `jump` stays 0.
- **Decay and hysteresis.** Sequence: all-ones, then alternating.
  - `level` follows 64, 56, 49, 43, 38, 34, 30, 27, 24, 21, 19, 17, 15.
  - `jump` drops 1 cycle after `level` = 15.
  - `jump` never drops before HOLD = 4 samples.
- **Reset mid-window.** Assert reset after 50 captured bits → all outputs 0 next cycle. After release, the next `sample_valid` counts 128 fresh bits only.
